// File: rtl/nco_seq_pkg.sv
// nco_seq_pkg
// Shared definitions for the NCO step sequencer:
//   seq_state_e     - sequencer FSM state encoding (IDLE / RUN)
//   calc_step_w()   - step word width from NCO LUT address bits and
//                     accumulator fractional bits (plus a sign bit)
//   DEFAULT_DWELL_W - default width of the per-segment dwell counter
package nco_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam int DEFAULT_DWELL_W = 16;

  // One extra bit over the accumulator width so the step can carry a sign
  // and drive reverse rotation.
  function automatic int calc_step_w(input int lut_length, input int phase_frac);
    return lut_length + phase_frac + 1;
  endfunction

endpackage

// File: rtl/nco_seq_table.sv
// nco_seq_table
// NUM_SEG-entry segment table holding (step, dwell) pairs.
// One synchronous write port, one combinational read port.
// Every entry is cleared to step=0, dwell=0 on reset.
//
// Ports:
//   iclk       in   clock
//   ireset     in   asynchronous reset, active-high
//   iwr_en     in   write strobe
//   iwr_addr   in   write address
//   iwr_step   in   step word to write
//   iwr_dwell  in   dwell count to write
//   ird_addr   in   read address
//   ord_step   out  step word at ird_addr (current contents)
//   ord_dwell  out  dwell count at ird_addr (current contents)
//
// Reads return the registered contents, so a write and a read of the same
// address in one cycle sees the old value.
module nco_seq_table
  import nco_seq_pkg::*;
#(
  parameter int STEP_W  = 9,
  parameter int DWELL_W = DEFAULT_DWELL_W,
  parameter int NUM_SEG = 8,
  parameter int ADDR_W  = $clog2(NUM_SEG)
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iwr_en,
  input  logic [ADDR_W-1:0]  iwr_addr,
  input  logic [STEP_W-1:0]  iwr_step,
  input  logic [DWELL_W-1:0] iwr_dwell,
  input  logic [ADDR_W-1:0]  ird_addr,
  output logic [STEP_W-1:0]  ord_step,
  output logic [DWELL_W-1:0] ord_dwell
);

  logic [STEP_W-1:0]  step_q  [NUM_SEG];
  logic [STEP_W-1:0]  step_d  [NUM_SEG];
  logic [DWELL_W-1:0] dwell_q [NUM_SEG];
  logic [DWELL_W-1:0] dwell_d [NUM_SEG];

  always_comb begin
    step_d  = step_q;
    dwell_d = dwell_q;
    if (iwr_en) begin
      step_d[iwr_addr]  = iwr_step;
      dwell_d[iwr_addr] = iwr_dwell;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        step_q[i]  <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  assign ord_step  = step_q[ird_addr];
  assign ord_dwell = dwell_q[ird_addr];

endmodule

// File: rtl/nco_step_sequencer.sv
// nco_step_sequencer
// Frequency-hop / sweep scheduler in front of lut_based_nco. Plays the
// segment table from entry 0 to the last index latched at start, holding
// each step word on ostep for max(dwell,1) cycles with no gaps. ostep is
// zero whenever idle so the NCO phase is frozen.
//
// Ports:
//   iclk       in   clock (shared with the NCO)
//   ireset     in   asynchronous reset, active-high
//   iwr_en     in   table write strobe
//   iwr_addr   in   table write address
//   iwr_step   in   step word to write
//   iwr_dwell  in   dwell cycles to write
//   ilast_seg  in   index of final segment, latched at start
//   istart     in   start request (pulse or level)
//   iabort     in   abort request, wins over istart
//   ostep      out  step word to NCO (registered)
//   oseg       out  segment currently playing (registered)
//   obusy      out  high while the sequence plays (registered)
//   odone      out  one-cycle pulse on normal completion (registered)
//   iloop      in   only with NCO_SEQ_LOOP_EN: wrap to segment 0 instead of
//                   completing, sampled at the final-segment end edge
//
// Build option: define NCO_SEQ_LOOP_EN to add the iloop port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ostep held at 0, waiting for istart without iabort
// ST_RUN  | playing segments; cnt_q counts down cycles left in segment
module nco_step_sequencer
  import nco_seq_pkg::*;
#(
  parameter int LUT_LENGTH = 6,
  parameter int PHASE_FRAC = 2,
  parameter int STEP_W     = calc_step_w(LUT_LENGTH, PHASE_FRAC),
  parameter int NUM_SEG    = 8,
  parameter int DWELL_W    = DEFAULT_DWELL_W,
  parameter int ADDR_W     = $clog2(NUM_SEG)
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iwr_en,
  input  logic [ADDR_W-1:0]  iwr_addr,
  input  logic [STEP_W-1:0]  iwr_step,
  input  logic [DWELL_W-1:0] iwr_dwell,
  input  logic [ADDR_W-1:0]  ilast_seg,
  input  logic               istart,
  input  logic               iabort,
  output logic [STEP_W-1:0]  ostep,
  output logic [ADDR_W-1:0]  oseg,
  output logic               obusy,
  output logic               odone
`ifdef NCO_SEQ_LOOP_EN
  ,
  input  logic               iloop
`endif
);

  seq_state_e         state_q, state_d;
  logic [STEP_W-1:0]  step_q,  step_d;
  logic [ADDR_W-1:0]  seg_q,   seg_d;
  logic [ADDR_W-1:0]  last_q,  last_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [ADDR_W-1:0]  rd_addr;
  logic [STEP_W-1:0]  rd_step;
  logic [DWELL_W-1:0] rd_dwell;
  logic [DWELL_W-1:0] dwell_load;
  logic               seg_end;
  logic               last_seg;
  logic               start_ok;
  logic               loop_req;

`ifdef NCO_SEQ_LOOP_EN
  assign loop_req = iloop;
`else
  assign loop_req = 1'b0;
`endif

  nco_seq_table #(
    .STEP_W  (STEP_W),
    .DWELL_W (DWELL_W),
    .NUM_SEG (NUM_SEG),
    .ADDR_W  (ADDR_W)
  ) u_table (
    .iclk      (iclk),
    .ireset    (ireset),
    .iwr_en    (iwr_en),
    .iwr_addr  (iwr_addr),
    .iwr_step  (iwr_step),
    .iwr_dwell (iwr_dwell),
    .ird_addr  (rd_addr),
    .ord_step  (rd_step),
    .ord_dwell (rd_dwell)
  );

  assign seg_end  = (cnt_q == DWELL_W'(1));
  assign last_seg = (seg_q == last_q);
  assign start_ok = istart && !iabort;

  // A zero dwell still plays for one cycle, so the counter never starts at 0
  // and never wraps while decrementing toward 1.
  assign dwell_load = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;

  // The only reads happen at segment-load edges: the next entry while more
  // segments remain, otherwise entry 0 (start, or loop wrap).
  always_comb begin
    rd_addr = '0;
    if (state_q == ST_RUN && !last_seg) begin
      rd_addr = seg_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      seg_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iabort) begin
          state_d = ST_IDLE;
        end else if (seg_end && last_seg && !loop_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    seg_d  = seg_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        step_d = '0;
        seg_d  = '0;
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start_ok) begin
          step_d = rd_step;
          cnt_d  = dwell_load;
          last_d = ilast_seg;
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (iabort) begin
          step_d = '0;
          seg_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b0;
        end else if (seg_end) begin
          if (!last_seg || loop_req) begin
            // rd_addr already points at seg_q+1, or 0 on a loop wrap.
            seg_d  = rd_addr;
            step_d = rd_step;
            cnt_d  = dwell_load;
          end else begin
            step_d = '0;
            seg_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        step_d = '0;
        seg_d  = '0;
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign ostep = step_q;
  assign oseg  = seg_q;
  assign obusy = busy_q;
  assign odone = done_q;

endmodule

// File: tb/tb_nco_step_sequencer.sv
module tb_nco_step_sequencer;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        iwr_en;
  logic [2:0]  iwr_addr;
  logic [8:0]  iwr_step;
  logic [15:0] iwr_dwell;
  logic [2:0]  ilast_seg;
  logic        istart;
  logic        iabort;
  logic [8:0]  ostep;
  logic [2:0]  oseg;
  logic        obusy;
  logic        odone;
`ifdef NCO_SEQ_LOOP_EN
  logic        iloop;
`endif

  int checks   = 0;
  int failures = 0;

  nco_step_sequencer dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iwr_en    (iwr_en),
    .iwr_addr  (iwr_addr),
    .iwr_step  (iwr_step),
    .iwr_dwell (iwr_dwell),
    .ilast_seg (ilast_seg),
    .istart    (istart),
    .iabort    (iabort),
    .ostep     (ostep),
    .oseg      (oseg),
    .obusy     (obusy),
    .odone     (odone)
`ifdef NCO_SEQ_LOOP_EN
    ,
    .iloop     (iloop)
`endif
  );

  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic wr_seg(input logic [2:0] a, input logic [8:0] s, input logic [15:0] d);
    iwr_en    = 1'b1;
    iwr_addr  = a;
    iwr_step  = s;
    iwr_dwell = d;
    tick();
    iwr_en    = 1'b0;
  endtask

  task automatic load_basic();
    wr_seg(3'd0, 9'h001, 16'd4);
    wr_seg(3'd1, 9'h008, 16'd2);
    wr_seg(3'd2, 9'h1FF, 16'd3);
  endtask

  task automatic pulse_start(input logic [2:0] last);
    ilast_seg = last;
    istart    = 1'b1;
    tick();
    istart    = 1'b0;
  endtask

  task automatic test_reset();
    ireset = 1'b1; iwr_en = 1'b0; iwr_addr = '0; iwr_step = '0; iwr_dwell = '0;
    ilast_seg = '0; istart = 1'b0; iabort = 1'b0;
`ifdef NCO_SEQ_LOOP_EN
    iloop = 1'b0;
`endif
    #12;
    ireset = 1'b0;
    tick();
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL reset_step got=%h exp=000", ostep); end
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", obusy); end
    checks++; if (oseg !== 3'd0)    begin failures++; $display("FAIL reset_seg got=%0d exp=0", oseg); end
    checks++; if (odone !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", odone); end
    // Reset mid-RUN, asserted between edges.
    wr_seg(3'd0, 9'h005, 16'd4);
    wr_seg(3'd1, 9'h006, 16'd4);
    pulse_start(3'd1);
    tick();
    checks++; if (ostep !== 9'h005) begin failures++; $display("FAIL reset_prerun_step got=%h exp=005", ostep); end
    #3;
    ireset = 1'b1;
    #1;
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL reset_async_step got=%h exp=000", ostep); end
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL reset_async_busy got=%b exp=0", obusy); end
    checks++; if (oseg !== 3'd0)    begin failures++; $display("FAIL reset_async_seg got=%0d exp=0", oseg); end
    tick();
    ireset = 1'b0;
    tick();
    checks++; if (odone !== 1'b0) begin failures++; $display("FAIL reset_nodone got=%b exp=0", odone); end
    checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", obusy); end
    // The table must be cleared: entry 0 now plays step 0 for one cycle.
    pulse_start(3'd0);
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL reset_table_step got=%h exp=000", ostep); end
    checks++; if (obusy !== 1'b1)   begin failures++; $display("FAIL reset_table_busy got=%b exp=1", obusy); end
    tick();
    checks++; if (odone !== 1'b1)   begin failures++; $display("FAIL reset_table_done got=%b exp=1", odone); end
    tick();
  endtask

  task automatic test_basic_sweep();
    logic [8:0] es [11] = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h008, 9'h008,
                            9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 9'h000};
    logic [2:0] eg [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    logic       eb [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       ed [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    load_basic();
    pulse_start(3'd2);
    for (int k = 0; k < 11; k++) begin
      checks++; if (ostep !== es[k]) begin failures++; $display("FAIL sweep_step k=%0d got=%h exp=%h", k, ostep, es[k]); end
      checks++; if (oseg !== eg[k])  begin failures++; $display("FAIL sweep_seg k=%0d got=%0d exp=%0d", k, oseg, eg[k]); end
      checks++; if (obusy !== eb[k]) begin failures++; $display("FAIL sweep_busy k=%0d got=%b exp=%b", k, obusy, eb[k]); end
      checks++; if (odone !== ed[k]) begin failures++; $display("FAIL sweep_done k=%0d got=%b exp=%b", k, odone, ed[k]); end
      tick();
    end
  endtask

  task automatic test_zero_dwell();
    wr_seg(3'd0, 9'h003, 16'd0);
    pulse_start(3'd0);
    checks++; if (ostep !== 9'h003) begin failures++; $display("FAIL zdwell_step got=%h exp=003", ostep); end
    checks++; if (obusy !== 1'b1)   begin failures++; $display("FAIL zdwell_busy got=%b exp=1", obusy); end
    tick();
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL zdwell_end_step got=%h exp=000", ostep); end
    checks++; if (odone !== 1'b1)   begin failures++; $display("FAIL zdwell_done got=%b exp=1", odone); end
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL zdwell_end_busy got=%b exp=0", obusy); end
    tick();
    checks++; if (odone !== 1'b0)   begin failures++; $display("FAIL zdwell_done_clear got=%b exp=0", odone); end
  endtask

  task automatic test_abort();
    load_basic();
    pulse_start(3'd2);
    for (int k = 0; k < 5; k++) tick();
    // Now in the 2nd cycle of seg1.
    checks++; if (ostep !== 9'h008) begin failures++; $display("FAIL abort_pre_step got=%h exp=008", ostep); end
    iabort = 1'b1;
    tick();
    iabort = 1'b0;
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL abort_step got=%h exp=000", ostep); end
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL abort_busy got=%b exp=0", obusy); end
    checks++; if (oseg !== 3'd0)    begin failures++; $display("FAIL abort_seg got=%0d exp=0", oseg); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (odone !== 1'b0) begin failures++; $display("FAIL abort_nodone k=%0d got=%b exp=0", k, odone); end
      checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy k=%0d got=%b exp=0", k, obusy); end
      tick();
    end
    // Abort and start together in IDLE: stays idle.
    iabort = 1'b1;
    istart = 1'b1;
    tick();
    iabort = 1'b0;
    istart = 1'b0;
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL abort_start_busy got=%b exp=0", obusy); end
    checks++; if (ostep !== 9'h000) begin failures++; $display("FAIL abort_start_step got=%h exp=000", ostep); end
    tick();
    checks++; if (obusy !== 1'b0)   begin failures++; $display("FAIL abort_start_busy2 got=%b exp=0", obusy); end
  endtask

  task automatic test_busy_writes();
    logic [8:0] es [9] = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h008, 9'h008, 9'h004, 9'h000, 9'h000};
    logic [2:0] eg [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0};
    logic       eb [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       ed [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    load_basic();
    pulse_start(3'd2);
    for (int k = 0; k < 9; k++) begin
      checks++; if (ostep !== es[k]) begin failures++; $display("FAIL busywr_step k=%0d got=%h exp=%h", k, ostep, es[k]); end
      checks++; if (oseg !== eg[k])  begin failures++; $display("FAIL busywr_seg k=%0d got=%0d exp=%0d", k, oseg, eg[k]); end
      checks++; if (obusy !== eb[k]) begin failures++; $display("FAIL busywr_busy k=%0d got=%b exp=%b", k, obusy, eb[k]); end
      checks++; if (odone !== ed[k]) begin failures++; $display("FAIL busywr_done k=%0d got=%b exp=%b", k, odone, ed[k]); end
      if (k == 0) begin
        iwr_en = 1'b1; iwr_addr = 3'd2; iwr_step = 9'h004; iwr_dwell = 16'd1;
      end else if (k == 1) begin
        iwr_en = 1'b0; istart = 1'b1;
      end else if (k == 2) begin
        istart = 1'b0;
      end else if (k == 3) begin
        // Lands on seg1's load edge: the old entry must be played.
        iwr_en = 1'b1; iwr_addr = 3'd1; iwr_step = 9'h0AA; iwr_dwell = 16'd5;
      end else if (k == 4) begin
        iwr_en = 1'b0;
      end
      tick();
    end
  endtask

`ifdef NCO_SEQ_LOOP_EN
  task automatic test_loop();
    logic [8:0] ps [9] = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h008, 9'h008, 9'h1FF, 9'h1FF, 9'h1FF};
    logic [2:0] pg [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    logic [8:0] xs;
    logic [2:0] xg;
    logic       xb;
    logic       xd;
    load_basic();
    iloop = 1'b1;
    pulse_start(3'd2);
    for (int k = 0; k < 20; k++) begin
      if (k < 18) begin
        xs = ps[k % 9]; xg = pg[k % 9]; xb = 1'b1; xd = 1'b0;
      end else begin
        xs = 9'h000; xg = 3'd0; xb = 1'b0; xd = (k == 18);
      end
      checks++; if (ostep !== xs) begin failures++; $display("FAIL loop_step k=%0d got=%h exp=%h", k, ostep, xs); end
      checks++; if (oseg !== xg)  begin failures++; $display("FAIL loop_seg k=%0d got=%0d exp=%0d", k, oseg, xg); end
      checks++; if (obusy !== xb) begin failures++; $display("FAIL loop_busy k=%0d got=%b exp=%b", k, obusy, xb); end
      checks++; if (odone !== xd) begin failures++; $display("FAIL loop_done k=%0d got=%b exp=%b", k, odone, xd); end
      if (k == 10) iloop = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_sweep();
    test_zero_dwell();
    test_abort();
    test_busy_writes();
`ifdef NCO_SEQ_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
